// File: rtl/vec_packer_pkg.sv
// Shared sample/vector types and clamp limits for the packer and neuron stages.
// The clamp helper is used when VEC_PACKER_CLAMP_EN is defined.
package vec_packer_pkg;

    localparam int VEC_LEN  = 4;
    localparam int SAMPLE_W = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef sample_t [VEC_LEN-1:0] vec_t;

    localparam sample_t SAMPLE_MIN = -8'sd127;
    localparam sample_t SAMPLE_MAX = 8'sd127;

    function automatic sample_t clamp_sample(input sample_t s);
        if (s < SAMPLE_MIN)
            return SAMPLE_MIN;
        else if (s > SAMPLE_MAX)
            return SAMPLE_MAX;
        else
            return s;
    endfunction

endpackage

// File: rtl/vec_fifo.sv
// DEPTH-entry synchronous FIFO of packed sample vectors.
// Pointers carry one extra wrap bit to tell full from empty.
module vec_fifo
    import vec_packer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic arst,
    input  logic push_i,
    input  vec_t data_i,
    input  logic pop_i,
    output vec_t data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        do_push, do_pop;
    vec_t        mem_q [DEPTH];

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    assign rptr_d = rptr_q + {{AW{1'b0}}, do_pop};

    assign data_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/vec_packer.sv
// Packs a serial sample stream into 4-element vectors buffered by a FIFO.
// Define VEC_PACKER_CLAMP_EN to store -128 as -127.
module vec_packer
    import vec_packer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_first,
    output logic             s_ready,
    output sample_t          X1,
    output sample_t          X2,
    output sample_t          X3,
    output sample_t          X4,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [1:0]           idx_q, idx_d;
    sample_t [2:0]        part_q, part_d;
    logic [CNT_W-1:0]     drop_q, drop_d;
    sample_t              samp;
    vec_t                 vec_in, head;
    logic                 accept, restart, push, pop;
    logic                 full, empty;

`ifdef VEC_PACKER_CLAMP_EN
    assign samp = clamp_sample(sample_t'(s_data));
`else
    assign samp = sample_t'(s_data);
`endif

    assign s_ready = !(idx_q == 2'd3 && full);
    assign accept  = s_valid && s_ready;
    assign restart = s_first && (idx_q != 2'd0);
    assign vec_in  = {samp, part_q};

    assign valid_out = !empty;
    assign pop       = valid_out && ready_in;
    assign drop_cnt  = drop_q;

    // Outputs read as zero whenever no vector is held
    assign X1 = valid_out ? head[0] : '0;
    assign X2 = valid_out ? head[1] : '0;
    assign X3 = valid_out ? head[2] : '0;
    assign X4 = valid_out ? head[3] : '0;

    always_comb begin
        idx_d  = idx_q;
        part_d = part_q;
        drop_d = drop_q;
        push   = 1'b0;
        if (accept) begin
            unique case (1'b1)
                restart: begin
                    part_d[0] = samp;
                    idx_d     = 2'd1;
                    if (drop_q != '1)
                        drop_d = drop_q + CNT_W'(1);
                end
                (!restart && idx_q == 2'd3): begin
                    push  = 1'b1;
                    idx_d = 2'd0;
                end
                default: begin
                    part_d[idx_q] = samp;
                    idx_d         = idx_q + 2'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            idx_q  <= '0;
            part_q <= '0;
            drop_q <= '0;
        end else begin
            idx_q  <= idx_d;
            part_q <= part_d;
            drop_q <= drop_d;
        end
    end

    vec_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .arst   (arst),
        .push_i (push),
        .data_i (vec_in),
        .pop_i  (pop),
        .data_o (head),
        .full_o (full),
        .empty_o(empty)
    );

endmodule

// File: doc/vec_packer.md
Name: vec_packer

Overview:
- Upstream feeder for the 4-input neural accelerator pipeline.
- Accepts a serial stream of signed 8-bit samples over a valid/ready handshake and assembles groups of four into one vector (X1..X4).
- Buffers completed vectors in a small FIFO and presents them to the accelerator input handshake (valid/ready).
- Decouples the sample source from accelerator back-pressure.

Parameters:
- DEPTH, 2, number of completed-vector FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the saturating dropped-vector counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- arst  input  1  asynchronous active-low reset.
- s_data  input  8  signed input sample.
- s_valid  input  1  s_data is valid this cycle.
- s_first  input  1  qualifies s_data as the first element (X1) of a new vector.
- s_ready  output  1  packer accepts a sample this cycle.
- X1, X2, X3, X4  output  8 each  signed vector at the FIFO head.
- valid_out  output  1  head vector is valid.
- ready_in  input  1  downstream accepts the head vector.
- drop_cnt  output  CNT_W  number of partial vectors discarded, saturating.

Behaviour:
- Reset (arst low, asynchronous): X1..X4=0, valid_out=0, drop_cnt=0, element counter idx=0, FIFO empty, s_ready=1 after release.
- Sample accept = s_valid & s_ready on a rising edge.
- Element order: first accepted sample → X1, second → X2, third → X3, fourth → X4. idx runs 0..3 and wraps to 0 on the 4th accept.
- Completion: the 4th accept (idx==3) writes the assembled vector into the FIFO on the same edge.
- s_ready = !(idx==3 && fifo_full). It is combinational from state only and never depends on ready_in. A pop in the same cycle does not raise s_ready.
- Pop = valid_out & ready_in. The FIFO head advances on the edge.
- valid_out = !fifo_empty. X1..X4 are driven from the head entry and hold stable while valid_out & !ready_in.
- Latency: with the FIFO empty, the 4th sample accepted at edge N gives valid_out=1 in the cycle after edge N. There is no bypass path.
- Push and pop in the same edge: both occur and occupancy is unchanged. This is legal at any occupancy where a push is allowed.
- Full: with fifo_full and idx==3, the 4th sample stalls (s_ready=0). Samples 1..3 of the next vector are still accepted while full.
- s_first=1 on accept with idx==0: normal behaviour.
- s_first=1 on accept with idx!=0:
  - The partial vector is discarded.
  - The current sample becomes X1 and idx becomes 1.
  - drop_cnt increments, saturating at 2^CNT_W-1.
- s_first is ignored when no accept occurs.
- s_first=0 with idx==0: accepted as X1; no error.
- Output values are never modified except by the optional feature.
- Reset mid-operation: partial vector, FIFO contents and drop_cnt are lost. Outputs return to their reset values immediately.
- FIFO pointers are log2(DEPTH)+1 bits wide. Full/empty is decided by comparing the MSB and the lower bits of the pointers.

Optional Feature:
- Macro: VEC_PACKER_CLAMP_EN.
- Defined: a sample of -128 (8'h80) is stored as -127 (8'h81), keeping the vector inside the neuron's symmetric [-127,127] range. All other values pass unchanged.
- Not defined: samples are stored verbatim, including -128.

Decomposition:
- Shared package:
  - VEC_LEN=4.
  - SAMPLE_W=8.
  - Signed sample typedef.
  - Vector typedef (4 × sample).
  - Clamp constants SAMPLE_MIN=-127 and SAMPLE_MAX=127, shared with the neuron stage.
- One sub-module, vec_fifo: DEPTH-entry synchronous FIFO of 32-bit packed vectors with push/pop/full/empty. The top level holds the assembly shift register, idx, the s_first/drop logic and the clamp.

Test Plan:
- Stream 1,2,3,4 with ready_in=1 → one cycle after the 4th accept, valid_out=1 with X1=1, X2=2, X3=3, X4=4; valid_out=0 one cycle after the pop.
- ready_in=0, stream 12 samples 10..21 → two vectors stored (10..13, 14..17); 18,19,20 accepted; s_ready=0 while 21 is offered; assert ready_in → after one pop, 21 is accepted and the vectors emerge in order.
- Samples 5,6 then 7 with s_first=1, then 8,9,10 → drop_cnt=1; output vector is 7,8,9,10.
- Sustained s_valid=1, ready_in=1 for 40 samples → 10 vectors, no stalls, s_ready constantly 1, one vector every 4 cycles.
- Sample -128 in the X2 slot → X2=-127 with VEC_PACKER_CLAMP_EN defined; X2=-128 without it.
- Assert arst low mid-vector with the FIFO holding 1 entry → valid_out=0, X1..X4=0, drop_cnt=0 immediately; after release, a fresh vector 1,2,3,4 is emitted correctly.
